// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: accepts one ex_mem instruction at a time,
// runs aligned loads/stores over a req/gnt/rvalid data bus, and produces a
// single-cycle writeback pulse toward mem_wb for every accepted instruction.
module mem_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [2:0]  mem_size_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  output logic        hold_flag_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  // Counter just wide enough to reach BUS_TIMEOUT; one bit when disabled.
  localparam int unsigned CW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(BUS_TIMEOUT);

  state_t        state, state_nxt;
  logic [CW-1:0] to_cnt;

  // Attributes of the in-flight access, captured at acceptance.
  logic [2:0]    size_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_addr_q;
  logic          we_q;

  // Decode of the incoming request.
  logic          is_mem, is_store;
  logic          illegal, misaligned, bad;
  logic          accept, start;
  logic [3:0]    be_enc;
  logic [31:0]   wdata_enc;

  // Bus-side events.
  logic          to_hit, store_done, load_grant, load_done, abort;

  // Select the addressed lane of a read word and extend it to 32 bits.
  function automatic logic [31:0] load_fmt(input logic [31:0] rdata,
                                           input logic [1:0]  off,
                                           input logic [2:0]  size);
    logic [31:0] lane;
    logic [31:0] res;
    lane = rdata >> {off, 3'b000};
    case (size[1:0])
      2'b00:   res = size[2] ? {24'h0, lane[7:0]}  : {{24{lane[7]}},  lane[7:0]};
      2'b01:   res = size[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  assign hold_flag_o = (state != IDLE);
  assign dbus_req_o  = (state == REQ);

  // Classify the request, build the bus encoding, and derive bus-side events.
  // NOTE: every signal written in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    is_store   = mem_we_i;
    is_mem     = mem_we_i | mem_re_i;
    illegal    = (mem_size_i == 3'b011) || (mem_size_i == 3'b110) ||
                 (mem_size_i == 3'b111) || (mem_we_i && mem_size_i[2]);
    misaligned = ((mem_size_i[1:0] == 2'b01) && mem_addr_i[0]) ||
                 ((mem_size_i == 3'b010) && (mem_addr_i[1:0] != 2'b00));
    bad        = is_mem && (illegal || misaligned);
    accept     = (state == IDLE) && in_valid_i;
    start      = accept && is_mem && !bad;

    be_enc    = 4'b1111;
    wdata_enc = mem_data_i;
    case (mem_size_i[1:0])
      2'b00: begin
        be_enc    = 4'b0001 << mem_addr_i[1:0];
        wdata_enc = {4{mem_data_i[7:0]}};
      end
      2'b01: begin
        be_enc    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_enc = {2{mem_data_i[15:0]}};
      end
      default: ;
    endcase

    to_hit     = (BUS_TIMEOUT != 0) && (to_cnt == TO_VAL);
    store_done = (state == REQ) && dbus_gnt_i && we_q;
    load_grant = (state == REQ) && dbus_gnt_i && !we_q;
    load_done  = (state == WAIT_R) && dbus_rvalid_i;
    // A grant or read response in the timeout cycle takes priority.
    abort      = to_hit && (((state == REQ) && !dbus_gnt_i) ||
                            ((state == WAIT_R) && !dbus_rvalid_i));
  end

  // Next-state logic for the bus handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ: begin
        if (store_done)      state_nxt = IDLE;
        else if (load_grant) state_nxt = WAIT_R;
        else if (abort)      state_nxt = IDLE;
      end
      WAIT_R:  if (load_done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset clears it at once so req drops asynchronously.
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Timeout counter: cleared when an access starts, counts while in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               to_cnt <= '0;
    else if (start)           to_cnt <= '0;
    else if (state != IDLE)   to_cnt <= to_cnt + 1'b1;
  end

  // Capture the access attributes needed after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q    <= '0;
      off_q     <= '0;
      rd_addr_q <= '0;
      we_q      <= 1'b0;
    end else if (accept) begin
      size_q    <= mem_size_i;
      off_q     <= mem_addr_i[1:0];
      rd_addr_q <= rd_addr_i;
      we_q      <= is_store;
    end
  end

  // Bus request fields, registered at start and held until the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
    end else if (start) begin
      dbus_we_o    <= is_store;
      dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
      dbus_be_o    <= be_enc;
      dbus_wdata_o <= is_store ? wdata_enc : 32'h0;
    end
  end

  // Writeback pulse and result registers; rd_* hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
      rd_wen_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid_o <= 1'b1;
        rd_addr_o  <= rd_addr_i;
        rd_data_o  <= rd_data_i;
        rd_wen_o   <= rd_wen_i && (rd_addr_i != 5'd0);
      end else if (accept && bad) begin
        wb_valid_o <= 1'b1;
        misalign_o <= 1'b1;
        rd_addr_o  <= rd_addr_i;
        rd_data_o  <= 32'h0;
        rd_wen_o   <= 1'b0;
      end else if (store_done) begin
        wb_valid_o <= 1'b1;
        rd_addr_o  <= rd_addr_q;
        rd_data_o  <= 32'h0;
        rd_wen_o   <= 1'b0;
      end else if (load_done) begin
        wb_valid_o <= 1'b1;
        rd_addr_o  <= rd_addr_q;
        rd_data_o  <= load_fmt(dbus_rdata_i, off_q, size_q);
        rd_wen_o   <= (rd_addr_q != 5'd0);
      end else if (abort) begin
        wb_valid_o <= 1'b1;
        bus_err_o  <= 1'b1;
        rd_addr_o  <= rd_addr_q;
        rd_data_o  <= 32'h0;
        rd_wen_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: non-memory pass-through, stores, loads with
// extension, x0 suppression, misaligned/illegal rejection, bus timeout,
// grant-vs-timeout priority and asynchronous reset mid-access.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_wen_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [2:0]  mem_size_i;
  logic        mem_we_i;
  logic        mem_re_i;
  logic        hold_flag_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;
  logic        misalign_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid_i),
    .rd_addr_i     (rd_addr_i),
    .rd_data_i     (rd_data_i),
    .rd_wen_i      (rd_wen_i),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .mem_size_i    (mem_size_i),
    .mem_we_i      (mem_we_i),
    .mem_re_i      (mem_re_i),
    .hold_flag_o   (hold_flag_o),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .rd_wen_o      (rd_wen_o),
    .misalign_o    (misalign_o),
    .bus_err_o     (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting edge, then scramble the
  // upstream fields so any use of unlatched inputs shows up.
  task automatic issue(input logic [4:0] rd, input logic [31:0] rdat, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] size, input logic we, input logic re);
    rd_addr_i  = rd;   rd_data_i  = rdat; rd_wen_i = wen;
    mem_addr_i = addr; mem_data_i = data; mem_size_i = size;
    mem_we_i   = we;   mem_re_i   = re;   in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    rd_addr_i  = ~rd;   rd_data_i  = ~rdat; rd_wen_i = ~wen;
    mem_addr_i = ~addr; mem_data_i = ~data; mem_size_i = 3'b111;
  endtask

  // Load with grant on the first REQ cycle (optionally preceded by a stray
  // rvalid) and rvalid on the cycle after the grant.
  task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] exp_be, input logic [31:0] rdata, input logic early_rv);
    issue(rd, 32'h0, 1'b1, addr, 32'h0, size, 1'b0, 1'b1);
    if (early_rv) begin
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'hBAD0_BAD0;
      tick();
      dbus_rvalid_i = 1'b0;
      check("early_rv_req", dbus_req_o, 1);
      check("early_rv_wb", wb_valid_o, 0);
    end
    check("ld_req", dbus_req_o, 1);
    check("ld_we", dbus_we_o, 0);
    check("ld_addr", dbus_addr_o, {addr[31:2], 2'b00});
    check("ld_be", dbus_be_o, exp_be);
    check("ld_wdata", dbus_wdata_o, 0);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    check("ld_wait_req", dbus_req_o, 0);
    check("ld_wait_hold", hold_flag_o, 1);
    check("ld_wait_wb", wb_valid_o, 0);
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = rdata;
    tick();
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = 32'h0;
    check("ld_wb", wb_valid_o, 1);
    check("ld_hold_after", hold_flag_o, 0);
    check("ld_rd_addr", rd_addr_o, rd);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid_i = 1'b0; rd_addr_i = '0; rd_data_i = '0; rd_wen_i = 1'b0;
    mem_addr_i = '0; mem_data_i = '0; mem_size_i = '0; mem_we_i = 1'b0; mem_re_i = 1'b0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    #12;
    check("rst_hold", hold_flag_o, 0);
    check("rst_req", dbus_req_o, 0);
    check("rst_flags", {wb_valid_o, rd_wen_o, misalign_o, bus_err_o, dbus_we_o}, 0);
    rst_n = 1'b1;
    tick();

    // Non-memory pass-through, latency 1, no stall.
    issue(5'd5, 32'h1234, 1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    check("nm_wb", wb_valid_o, 1);
    check("nm_data", rd_data_o, 32'h1234);
    check("nm_addr", rd_addr_o, 5);
    check("nm_wen", rd_wen_o, 1);
    check("nm_hold", hold_flag_o, 0);
    check("nm_req", dbus_req_o, 0);
    tick();
    check("nm_pulse", wb_valid_o, 0);
    check("nm_data_held", rd_data_o, 32'h1234);
    check("nm_hold2", hold_flag_o, 0);

    // Non-memory write to x0 is suppressed.
    issue(5'd0, 32'h55, 1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    check("nm_x0_wb", wb_valid_o, 1);
    check("nm_x0_wen", rd_wen_o, 0);
    tick();

    // SB at 0x1003, grant in the third REQ cycle.
    issue(5'd7, 32'h0, 1'b0, 32'h1003, 32'hAABB_CCDD, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("sb_hold", hold_flag_o, 1);
      check("sb_req", dbus_req_o, 1);
      check("sb_we", dbus_we_o, 1);
      check("sb_addr", dbus_addr_o, 32'h1000);
      check("sb_be", dbus_be_o, 4'b1000);
      check("sb_wdata", dbus_wdata_o, 32'hDDDD_DDDD);
      check("sb_no_wb", wb_valid_o, 0);
      if (i == 2) dbus_gnt_i = 1'b1;
      tick();
    end
    dbus_gnt_i = 1'b0;
    check("sb_wb", wb_valid_o, 1);
    check("sb_wen", rd_wen_o, 0);
    check("sb_hold_done", hold_flag_o, 0);
    check("sb_req_done", dbus_req_o, 0);
    tick();
    check("sb_pulse", wb_valid_o, 0);

    // SH at 0x22, immediate grant: 2-cycle latency.
    issue(5'd8, 32'h0, 1'b0, 32'h22, 32'h1357_9BDF, 3'b001, 1'b1, 1'b1);
    check("sh_be", dbus_be_o, 4'b1100);
    check("sh_wdata", dbus_wdata_o, 32'h9BDF_9BDF);
    check("sh_we", dbus_we_o, 1);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    check("sh_wb", wb_valid_o, 1);
    check("sh_wen", rd_wen_o, 0);
    tick();

    // LB vs LBU from lane 2 of 0x0080FF00.
    do_load(5'd10, 32'h2002, 3'b000, 4'b0100, 32'h0080_FF00, 1'b1);
    check("lb_data", rd_data_o, 32'hFFFF_FF80);
    check("lb_wen", rd_wen_o, 1);
    tick();
    do_load(5'd11, 32'h2002, 3'b100, 4'b0100, 32'h0080_FF00, 1'b0);
    check("lbu_data", rd_data_o, 32'h0000_0080);
    tick();

    // LHU from the upper half.
    do_load(5'd12, 32'h2006, 3'b101, 4'b1100, 32'h9876_5432, 1'b0);
    check("lhu_data", rd_data_o, 32'h0000_9876);
    tick();

    // LW to x0: pulse without a register write.
    do_load(5'd0, 32'h3000, 3'b010, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    check("lw_x0_wen", rd_wen_o, 0);
    check("lw_x0_data", rd_data_o, 32'hDEAD_BEEF);
    tick();

    // Misaligned LW: no bus activity, one-cycle misalign pulse.
    issue(5'd13, 32'h0, 1'b1, 32'h4001, 32'h0, 3'b010, 1'b0, 1'b1);
    check("mis_flag", misalign_o, 1);
    check("mis_wb", wb_valid_o, 1);
    check("mis_wen", rd_wen_o, 0);
    check("mis_req", dbus_req_o, 0);
    check("mis_hold", hold_flag_o, 0);
    tick();
    check("mis_pulse", misalign_o, 0);
    check("mis_req2", dbus_req_o, 0);

    // Illegal: store with an unsigned size code.
    issue(5'd14, 32'h0, 1'b0, 32'h4000, 32'h0, 3'b100, 1'b1, 1'b0);
    check("ill_flag", misalign_o, 1);
    check("ill_req", dbus_req_o, 0);
    tick();

    // Timeout: counter 0..4 across five REQ cycles, then abort.
    issue(5'd15, 32'h0, 1'b0, 32'h5000, 32'h1122_3344, 3'b010, 1'b1, 1'b0);
    begin
      int n = 0;
      while (hold_flag_o && n < 20) begin
        n++;
        tick();
      end
      check("to_cycles", 32'(n), 5);
    end
    check("to_err", bus_err_o, 1);
    check("to_wb", wb_valid_o, 1);
    check("to_wen", rd_wen_o, 0);
    check("to_req", dbus_req_o, 0);
    tick();
    check("to_pulse", bus_err_o, 0);

    // Grant in the timeout cycle completes the store normally.
    issue(5'd16, 32'h0, 1'b0, 32'h6000, 32'h0, 3'b010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("race_req", dbus_req_o, 1);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    check("race_wb", wb_valid_o, 1);
    check("race_err", bus_err_o, 0);
    tick();

    // Produce a nonzero result, then reset during WAIT_R.
    issue(5'd17, 32'hCAFE_F00D, 1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    tick();
    issue(5'd18, 32'h0, 1'b1, 32'h7000, 32'h0, 3'b010, 1'b0, 1'b1);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    check("rr_hold_before", hold_flag_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_hold", hold_flag_o, 0);
    check("rr_req", dbus_req_o, 0);
    check("rr_addr", dbus_addr_o, 0);
    check("rr_data", rd_data_o, 0);
    check("rr_rd", {rd_addr_o, dbus_be_o}, 0);
    check("rr_flags", {wb_valid_o, rd_wen_o, misalign_o, bus_err_o, dbus_we_o}, 0);
    #2;
    rst_n = 1'b1;
    tick();

    // LH after reset: lower half of 0x80010000 is zero.
    do_load(5'd9, 32'h10, 3'b001, 4'b0011, 32'h8001_0000, 1'b0);
    check("lh_data", rd_data_o, 32'h0000_0000);
    check("lh_wen", rd_wen_o, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
